// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one single-ported SRAM between an instruction-fetch port (read
//   only) and a data port (read/write). Grants are decided combinationally in
//   the request cycle. The data port normally wins. The fetch port is forced
//   through once it has been denied STARVE_LIMIT consecutive cycles. Read data
//   returns one cycle after the grant, which matches the SRAM's one-cycle
//   read latency.
//
// Handshake:
//   A request is accepted in a cycle when its gnt is high in that cycle. The
//   requester must hold req/addr/data stable until it sees gnt. For a read,
//   the matching rvalid pulses for exactly one cycle, one cycle after gnt,
//   and rdata is valid only while rvalid is high (it is 0 otherwise). A write
//   never produces an rvalid. A new grant may be issued every cycle.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_gnt/if_rvalid/if_rdata  fetch accept, read-valid and read data
//   dm_req/dm_w_en/dm_addr/dm_wdata  data request (w_en==0 means read)
//   dm_gnt/dm_rvalid/dm_rdata  data accept, read-valid and read data
//   sram_w_en/sram_addr/sram_wdata/sram_rdata  shared SRAM port
//   if_stall_cnt/dm_stall_cnt  per-port denied-cycle counters
//   dbg_last_op              current FSM state (last_op), for observation
//
// Configuration:
//   SRAM_ARB_STATS_EN  when defined, the stall counters are live. Each one
//                      counts the cycles in which its port requested but was
//                      not granted, and wraps at 2^32. When not defined,
//                      both counter outputs are tied to 0.
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic [3:0]  dm_w_en,
   input  logic [15:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic [3:0]  sram_w_en,
   output logic [15:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic [31:0] if_stall_cnt,
   output logic [31:0] dm_stall_cnt,
   output logic [1:0]  dbg_last_op
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_IF_RD = 2'd1,
      S_DM_RD = 2'd2,
      S_DM_WR = 2'd3
   } op_t;

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   op_t           last_op;
   op_t           next_op;
   logic [CW-1:0] starve_cnt;
   logic          if_force;

   // The fetch port is forced through once it has waited the full limit.
   assign if_force = if_req && (starve_cnt == LIMIT);

   // Grant decision and SRAM port mux. Everything is held idle during reset.
   always_comb begin
      if_gnt     = 1'b0;
      dm_gnt     = 1'b0;
      sram_w_en  = 4'b0000;
      sram_addr  = if_addr;
      sram_wdata = 32'h0;
      next_op    = S_IDLE;
      if (!rst) begin
         if (dm_req && !if_force) begin
            dm_gnt     = 1'b1;
            sram_addr  = dm_addr;
            sram_w_en  = dm_w_en;
            sram_wdata = dm_wdata;
            next_op    = (dm_w_en != 4'b0000) ? S_DM_WR : S_DM_RD;
         end else if (if_req) begin
            if_gnt  = 1'b1;
            next_op = S_IF_RD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_op <= S_IDLE;
      end else begin
         last_op <= next_op;
      end
   end

   // Counts consecutive denied fetch cycles. It saturates at the limit, and
   // the forced grant then clears it.
   always_ff @(posedge clk) begin
      if (rst || !if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Read data from the SRAM arrives in the cycle after the grant. Gating
   // with rst drops a read response that falls into a reset cycle.
   assign if_rvalid   = !rst && (last_op == S_IF_RD);
   assign dm_rvalid   = !rst && (last_op == S_DM_RD);
   assign if_rdata    = if_rvalid ? sram_rdata : 32'h0;
   assign dm_rdata    = dm_rvalid ? sram_rdata : 32'h0;
   assign dbg_last_op = last_op;

`ifdef SRAM_ARB_STATS_EN
   logic [31:0] if_stall_q;
   logic [31:0] dm_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         if_stall_q <= 32'h0;
         dm_stall_q <= 32'h0;
      end else begin
         if (if_req && !if_gnt) if_stall_q <= if_stall_q + 32'h1;
         if (dm_req && !dm_gnt) dm_stall_q <= dm_stall_q + 32'h1;
      end
   end

   assign if_stall_cnt = if_stall_q;
   assign dm_stall_cnt = dm_stall_q;
`else
   assign if_stall_cnt = 32'h0;
   assign dm_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with STARVE_LIMIT=4. A small behavioural
// SRAM with one-cycle registered read data sits on the shared port. Inputs
// change 1 time unit after a rising edge. Outputs are sampled 1 unit after
// that, well away from the next edge. The expected stall counts depend on
// whether SRAM_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic [3:0]  dm_w_en;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic [3:0]  sram_w_en;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [31:0] if_stall_cnt;
   logic [31:0] dm_stall_cnt;
   logic [1:0]  dbg_last_op;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   sram_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .dm_req       (dm_req),
      .dm_w_en      (dm_w_en),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_gnt       (dm_gnt),
      .dm_rvalid    (dm_rvalid),
      .dm_rdata     (dm_rdata),
      .sram_w_en    (sram_w_en),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .if_stall_cnt (if_stall_cnt),
      .dm_stall_cnt (dm_stall_cnt),
      .dbg_last_op  (dbg_last_op)
   );

   // Clock block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: byte-enabled write, read data registered by one cycle.
   bit [31:0] mem [0:255];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (sram_w_en[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr[9:2]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      if_req   = 1'b0;
      dm_req   = 1'b0;
      dm_w_en  = 4'b0000;
      dm_wdata = 32'h0;
   endtask

   logic        exp_if;
   logic        prev_if;
   logic [31:0] exp_if_stall;
   logic [31:0] exp_dm_stall;

   initial begin
      rst      = 1'b1;
      if_addr  = 16'h0;
      dm_addr  = 16'h0;
      sram_rdata = 32'h0;
      set_idle();
      repeat (2) step();

      // Requests during reset: nothing is granted and nothing is written.
      if_req = 1'b1; dm_req = 1'b1; dm_w_en = 4'b1111; dm_wdata = 32'h12345678;
      #1;
      check("rst_if_gnt", 32'(if_gnt), 32'h0);
      check("rst_dm_gnt", 32'(dm_gnt), 32'h0);
      check("rst_sram_w_en", 32'(sram_w_en), 32'h0);
      check("rst_rvalids", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
      step();
      check("rst_last_op", 32'(dbg_last_op), 32'h0);
      rst = 1'b0;
      set_idle();
      #1;
      check("post_rst_rvalids", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
      check("post_rst_if_stall", if_stall_cnt, 32'h0);
      check("post_rst_dm_stall", dm_stall_cnt, 32'h0);

      // No grant: the port shows the fetch address, with w_en and wdata at 0.
      if_addr = 16'h0044; dm_wdata = 32'hA5A5A5A5; dm_w_en = 4'b1111;
      #1;
      check("idle_sram_addr", 32'(sram_addr), 32'h0044);
      check("idle_sram_w_en", 32'(sram_w_en), 32'h0);
      check("idle_sram_wdata", sram_wdata, 32'h0);
      check("idle_gnts", {30'h0, if_gnt, dm_gnt}, 32'h0);

      // Preload fetch words through the data port.
      dm_req = 1'b1; dm_w_en = 4'b1111; dm_addr = 16'h0010; dm_wdata = 32'h00000013;
      #1;
      check("pre_dm_gnt", 32'(dm_gnt), 32'h1);
      step();
      dm_addr = 16'h0020; dm_wdata = 32'h11111111;
      #1;
      check("pre_no_rvalid", 32'(dm_rvalid), 32'h0);
      check("pre_last_op_wr", 32'(dbg_last_op), 32'h3);
      step();

      // Fetch only: the word at 0x0010 returns one cycle after the grant.
      set_idle(); dm_w_en = 4'b1111;
      if_req = 1'b1; if_addr = 16'h0010;
      #1;
      check("if_gnt", 32'(if_gnt), 32'h1);
      check("if_dm_gnt", 32'(dm_gnt), 32'h0);
      check("if_sram_addr", 32'(sram_addr), 32'h0010);
      check("if_sram_w_en", 32'(sram_w_en), 32'h0);
      step();
      set_idle();
      #1;
      check("if_rvalid", 32'(if_rvalid), 32'h1);
      check("if_rdata", if_rdata, 32'h00000013);
      check("if_no_dm_rvalid", 32'(dm_rvalid), 32'h0);
      check("if_dm_rdata_zero", dm_rdata, 32'h0);

      // Data write, then a read of the same address.
      dm_req = 1'b1; dm_w_en = 4'b1111; dm_addr = 16'h0100; dm_wdata = 32'hDEADBEEF;
      #1;
      check("wr_dm_gnt", 32'(dm_gnt), 32'h1);
      check("wr_sram_addr", 32'(sram_addr), 32'h0100);
      check("wr_sram_w_en", 32'(sram_w_en), 32'hF);
      check("wr_sram_wdata", sram_wdata, 32'hDEADBEEF);
      step();
      dm_w_en = 4'b0000;
      #1;
      check("wr_no_rvalid", 32'(dm_rvalid), 32'h0);
      check("rd_dm_gnt", 32'(dm_gnt), 32'h1);
      step();
      dm_w_en = 4'b0011; dm_wdata = 32'h0000CAFE;
      #1;
      check("rd_dm_rvalid", 32'(dm_rvalid), 32'h1);
      check("rd_dm_rdata", dm_rdata, 32'hDEADBEEF);
      check("rd_if_rdata_zero", if_rdata, 32'h0);
      check("pw_sram_w_en", 32'(sram_w_en), 32'h3);
      step();
      dm_w_en = 4'b0000;
      step();
      set_idle();
      #1;
      check("pw_rdata", dm_rdata, 32'hDEADCAFE);

      // Both ports request every cycle. The data port wins 4 cycles, then the
      // fetch port is forced, and the pattern repeats.
      if_req = 1'b1; if_addr = 16'h0020;
      dm_req = 1'b1; dm_w_en = 4'b0000; dm_addr = 16'h0100;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp_if = ((i % 5) == 4);
         check($sformatf("st_if_gnt_%0d", i), 32'(if_gnt), 32'(exp_if));
         check($sformatf("st_dm_gnt_%0d", i), 32'(dm_gnt), 32'(!exp_if));
         check($sformatf("st_addr_%0d", i), 32'(sram_addr), exp_if ? 32'h0020 : 32'h0100);
         exp_q.push_back(exp_if ? 32'h11111111 : 32'hDEADCAFE);
         prev_if = exp_if;
         step();
         check($sformatf("st_if_rvalid_%0d", i), 32'(if_rvalid), 32'(prev_if));
         check($sformatf("st_dm_rvalid_%0d", i), 32'(dm_rvalid), 32'(!prev_if));
         check($sformatf("st_rdata_%0d", i), prev_if ? if_rdata : dm_rdata, exp_q.pop_front());
      end
`ifdef SRAM_ARB_STATS_EN
      exp_if_stall = 32'd8; exp_dm_stall = 32'd2;
`else
      exp_if_stall = 32'd0; exp_dm_stall = 32'd0;
`endif
      check("st_if_stall", if_stall_cnt, exp_if_stall);
      check("st_dm_stall", dm_stall_cnt, exp_dm_stall);

      // Reset in the cycle after a data read grant drops that response.
      set_idle();
      dm_req = 1'b1; dm_addr = 16'h0100;
      #1;
      check("rr_dm_gnt", 32'(dm_gnt), 32'h1);
      step();
      rst = 1'b1;
      #1;
      check("rr_dm_rvalid", 32'(dm_rvalid), 32'h0);
      check("rr_dm_rdata", dm_rdata, 32'h0);
      check("rr_dm_gnt_rst", 32'(dm_gnt), 32'h0);
      step();
      rst = 1'b0;
      set_idle();
      #1;
      check("rr_last_op", 32'(dbg_last_op), 32'h0);
      check("rr_rvalids", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
      check("rr_if_stall", if_stall_cnt, 32'h0);
      check("rr_dm_stall", dm_stall_cnt, 32'h0);

      // Three denied fetch cycles, then a quiet cycle.
      if_req = 1'b1; dm_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("s3_dm_gnt_%0d", i), 32'(dm_gnt), 32'h1);
         step();
      end
      set_idle();
      #1;
`ifdef SRAM_ARB_STATS_EN
      exp_if_stall = 32'd3;
`else
      exp_if_stall = 32'd0;
`endif
      check("s3_if_stall", if_stall_cnt, exp_if_stall);
      check("s3_dm_stall", dm_stall_cnt, 32'h0);
      step();

      // The quiet cycle cleared the starvation count, so the data port again
      // gets a full 4 grants before the fetch port is forced.
      if_req = 1'b1; dm_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("clr_if_gnt_%0d", i), 32'(if_gnt), 32'(i == 4));
         check($sformatf("clr_dm_gnt_%0d", i), 32'(dm_gnt), 32'(i != 4));
         step();
      end
      set_idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive cycles if_req may be denied before it is forced a grant.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-005 SHALL have port if_addr  input  16  instruction byte address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-008 SHALL have port if_rdata  output  32  fetch read data.
REQ-009 SHALL have port dm_req  input  1  data-port request (read or write).
REQ-010 SHALL have port dm_w_en  input  4  byte write enables; 4'b0000 = read.
REQ-011 SHALL have port dm_addr  input  16  data byte address.
REQ-012 SHALL have port dm_wdata  input  32  data write value.
REQ-013 SHALL have port dm_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port dm_rvalid  output  1  data read data valid.
REQ-015 SHALL have port dm_rdata  output  32  data read data.
REQ-016 SHALL have port sram_w_en  output  4  to shared SRAM w_en.
REQ-017 SHALL have port sram_addr  output  16  to shared SRAM address.
REQ-018 SHALL have port sram_wdata  output  32  to shared SRAM write_data.
REQ-019 SHALL have port sram_rdata  input  32  from shared SRAM read_data (valid one cycle after address).
REQ-020 SHALL have ports if_stall_cnt and dm_stall_cnt  output  32 each  stall counters (see Configuration).

Function
REQ-021 SHALL decide grants combinationally in the request cycle; at most one of if_gnt/dm_gnt high per cycle.
REQ-022 SHALL grant dm when dm_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case it SHALL grant if.
REQ-023 SHALL grant if when if_req=1 and dm_req=0.
REQ-024 SHALL, on dm grant, drive sram_addr=dm_addr, sram_w_en=dm_w_en, sram_wdata=dm_wdata.
REQ-025 SHALL, on if grant, drive sram_addr=if_addr, sram_w_en=0.
REQ-026 SHALL, with no grant, drive sram_w_en=0, sram_addr=if_addr, sram_wdata=0.
REQ-027 SHALL keep FSM state last_op in {S_IDLE, S_IF_RD, S_DM_RD, S_DM_WR}, next state set by the grant type of the current cycle (none→S_IDLE).
REQ-028 SHALL assert if_rvalid exactly when last_op==S_IF_RD and dm_rvalid exactly when last_op==S_DM_RD; latency 1 cycle from grant.
REQ-029 SHALL drive if_rdata/dm_rdata = sram_rdata while the respective rvalid is high, else 0.
REQ-030 SHALL never assert rvalid for a write (S_DM_WR).
REQ-031 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0; clear it when if_gnt=1 or if_req=0.
REQ-032 SHALL accept back-to-back grants every cycle with no bubble.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set last_op=S_IDLE, starve_cnt=0, both stall counters=0.
REQ-034 SHALL hold all grants, sram_w_en, and rvalids at 0 while rst=1; no rvalid in the cycle after reset release for a request made during reset.

Configuration
REQ-035 SHALL, with macro SRAM_ARB_STATS_EN defined, increment if_stall_cnt each cycle if_req=1 and if_gnt=0, and dm_stall_cnt each cycle dm_req=1 and dm_gnt=0 (wrap at 2^32).
REQ-036 SHALL, without SRAM_ARB_STATS_EN, tie both stall counter outputs to 0 and instantiate no counter registers.

Verification
REQ-037 SHALL cover: if_req only, if_addr=0x0010, SRAM word 0x00000013 -> if_gnt=1, next cycle if_rvalid=1, if_rdata=0x00000013.
REQ-038 SHALL cover: dm write w_en=4'b1111 addr 0x0100 data 0xDEADBEEF, then dm read 0x0100 -> no rvalid after write, dm_rdata=0xDEADBEEF one cycle after read grant.
REQ-039 SHALL cover: if_req and dm_req held high continuously, STARVE_LIMIT=4 -> dm granted 4 cycles, if granted 5th cycle, pattern repeats.
REQ-040 SHALL cover: rst asserted in cycle after a dm read grant -> dm_rvalid=0 that cycle, all state zero after release.
REQ-041 SHALL cover: with SRAM_ARB_STATS_EN, 3 cycles of if denied -> if_stall_cnt=3; without the macro -> reads 0.
